// File: rtl/mac_job_sched.sv
// Job scheduler and configuration sequencer for the streaming MAC datapath.
// Define MAC_SCHED_PERF_EN to build the RUN-cycle performance counter; otherwise perf_cycles_o is 0.
module mac_job_sched #(
    parameter int  CMD_DEPTH   = 2,
    parameter int  MAC_CNT_LEN = 4096,
    parameter int  NOUT_W      = 16,
    localparam int LEN_W       = $clog2(MAC_CNT_LEN)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear_i,
    input  logic              cmd_TVALID,
    output logic              cmd_TREADY,
    input  logic              cmd_simple_mul,
    input  logic [4:0]        cmd_shift,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [NOUT_W-1:0] cmd_nout,
    output logic              mac_reg_simple_mul,
    output logic [4:0]        mac_reg_shift,
    output logic [LEN_W-1:0]  mac_reg_len,
    input  logic              mac_d_TVALID,
    input  logic              mac_d_TREADY,
    output logic              stream_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       job_cnt_o,
    output logic [31:0]       perf_cycles_o
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int DW = 1 + 5 + LEN_W + NOUT_W;
    localparam logic [AW:0]       PTR_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]       PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [NOUT_W-1:0] NOUT_ZERO = {NOUT_W{1'b0}};
    localparam logic [NOUT_W-1:0] NOUT_ONE  = {{(NOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, state_nx_s;
    logic [DW-1:0]       mem_r [CMD_DEPTH];
    logic [AW:0]         wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
    logic                fifo_empty_s, fifo_full_s, push_s, pop_s, hs_s, last_hs_s, busy_nx_s;
    logic                head_mul_s;
    logic [4:0]          head_shift_s;
    logic [LEN_W-1:0]    head_len_s;
    logic [NOUT_W-1:0]   head_nout_s;
    logic [NOUT_W-1:0]   nout_r, out_cnt_r;
    logic                mul_r, stream_en_r, busy_r, done_r, err_r;
    logic [4:0]          shift_r;
    logic [LEN_W-1:0]    len_r;
    logic [15:0]         job_cnt_r;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign cmd_TREADY   = !fifo_full_s;
    assign push_s       = cmd_TVALID && !fifo_full_s && !clear_i;
    assign hs_s         = mac_d_TVALID && mac_d_TREADY;
    assign last_hs_s    = hs_s && (out_cnt_r == (nout_r - NOUT_ONE));
    assign {head_mul_s, head_shift_s, head_len_s, head_nout_s} = mem_r[rd_ptr_r[AW-1:0]];

    // Next-state, pop decision and next FIFO occupancy; clear_i overrides everything.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = (head_nout_s != NOUT_ZERO) ? ST_LOAD : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nx_s = ST_RUN;
            ST_RUN: begin
                if (last_hs_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
        if (clear_i) begin
            state_nx_s  = ST_IDLE;
            pop_s       = 1'b0;
            wr_ptr_nx_s = PTR_ZERO;
            rd_ptr_nx_s = PTR_ZERO;
        end else begin
            wr_ptr_nx_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_nx_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        end
        busy_nx_s = (state_nx_s != ST_IDLE) || (wr_ptr_nx_s != rd_ptr_nx_s);
    end

    // State register, FIFO pointers and descriptor storage.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            state_r  <= state_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {cmd_simple_mul, cmd_shift, cmd_len, cmd_nout};
            end
        end
    end

    // Job configuration latched on pop; output-handshake counter for the running job.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mul_r     <= 1'b0;
            shift_r   <= 5'd0;
            len_r     <= {LEN_W{1'b0}};
            nout_r    <= NOUT_ZERO;
            out_cnt_r <= NOUT_ZERO;
        end else begin
            if (pop_s) begin
                mul_r   <= head_mul_s;
                shift_r <= head_shift_s;
                len_r   <= head_len_s;
                nout_r  <= head_nout_s;
            end
            if (state_r == ST_LOAD) begin
                out_cnt_r <= NOUT_ZERO;
            end else if ((state_r == ST_RUN) && hs_s) begin
                out_cnt_r <= out_cnt_r + NOUT_ONE;
            end
        end
    end

    // Registered status outputs; an error job is one that enters DONE straight from IDLE.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stream_en_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            job_cnt_r   <= 16'd0;
        end else begin
            stream_en_r <= (state_nx_s == ST_RUN);
            busy_r      <= busy_nx_s;
            done_r      <= (state_nx_s == ST_DONE);
            err_r       <= (state_nx_s == ST_DONE) && (state_r == ST_IDLE);
            if ((state_nx_s == ST_DONE) && (state_r == ST_RUN)) begin
                job_cnt_r <= job_cnt_r + 16'd1;
            end
        end
    end

`ifdef MAC_SCHED_PERF_EN
    logic [31:0] perf_cnt_r, perf_run_s, perf_cycles_r;
    assign perf_run_s = (perf_cnt_r == 32'hFFFF_FFFF) ? perf_cnt_r : (perf_cnt_r + 32'd1);

    // RUN-cycle counter, snapshotted on DONE entry (includes the final RUN cycle).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_cnt_r    <= 32'd0;
            perf_cycles_r <= 32'd0;
        end else begin
            if (state_r == ST_LOAD) begin
                perf_cnt_r <= 32'd0;
            end else if (state_r == ST_RUN) begin
                perf_cnt_r <= perf_run_s;
            end
            if (state_nx_s == ST_DONE) begin
                perf_cycles_r <= (state_r == ST_RUN) ? perf_run_s : 32'd0;
            end
        end
    end
    assign perf_cycles_o = perf_cycles_r;
`else
    assign perf_cycles_o = 32'd0;
`endif

    assign mac_reg_simple_mul = mul_r;
    assign mac_reg_shift      = shift_r;
    assign mac_reg_len        = len_r;
    assign stream_en_o        = stream_en_r;
    assign busy_o             = busy_r;
    assign done_o             = done_r;
    assign err_o              = err_r;
    assign job_cnt_o          = job_cnt_r;

endmodule

// File: tb/tb_mac_job_sched.sv
// Self-checking bench for mac_job_sched: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a job-level reference model.
module tb_mac_job_sched;
    localparam int CMD_DEPTH = 2;
    localparam int NOUT_W    = 16;
    localparam int LEN_W     = 12;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              clear_i = 1'b0;
    logic              cmd_TVALID = 1'b0;
    logic              cmd_TREADY;
    logic              cmd_simple_mul = 1'b0;
    logic [4:0]        cmd_shift = 5'd0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [NOUT_W-1:0] cmd_nout = '0;
    logic              mac_reg_simple_mul;
    logic [4:0]        mac_reg_shift;
    logic [LEN_W-1:0]  mac_reg_len;
    logic              mac_d_TVALID = 1'b0;
    logic              mac_d_TREADY = 1'b0;
    logic              stream_en_o, busy_o, done_o, err_o;
    logic [15:0]       job_cnt_o;
    logic [31:0]       perf_cycles_o;

    mac_job_sched #(.CMD_DEPTH(CMD_DEPTH), .MAC_CNT_LEN(4096), .NOUT_W(NOUT_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear_i(clear_i),
        .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY),
        .cmd_simple_mul(cmd_simple_mul), .cmd_shift(cmd_shift), .cmd_len(cmd_len), .cmd_nout(cmd_nout),
        .mac_reg_simple_mul(mac_reg_simple_mul), .mac_reg_shift(mac_reg_shift), .mac_reg_len(mac_reg_len),
        .mac_d_TVALID(mac_d_TVALID), .mac_d_TREADY(mac_d_TREADY),
        .stream_en_o(stream_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .job_cnt_o(job_cnt_o), .perf_cycles_o(perf_cycles_o)
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit wrap_preload = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job level) ----------------
    typedef struct packed {
        logic              mul;
        logic [4:0]        sh;
        logic [LEN_W-1:0]  len;
        logic [NOUT_W-1:0] nout;
    } desc_t;

    desc_t q[$];
    desc_t d_pop, d_new;
    bit    j_load = 0, j_run = 0, j_end = 0;
    int    j_left = 0, j_runcyc = 0;
    bit    m_hs, m_can_push;
    logic              e_mul = 0, e_stream = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [4:0]        e_sh = 0;
    logic [LEN_W-1:0]  e_len = 0;
    logic [15:0]       e_jobcnt = 0;
    logic [31:0]       e_perf = 0;

    initial forever begin
        @(posedge ap_clk or negedge ap_rst_n);
        if (!ap_rst_n) begin
            q.delete();
            j_load = 0; j_run = 0; j_end = 0; j_left = 0; j_runcyc = 0;
            e_mul = 0; e_sh = 0; e_len = 0; e_stream = 0; e_busy = 0;
            e_done = 0; e_err = 0; e_jobcnt = 0; e_perf = 0;
        end else begin
            m_hs       = mac_d_TVALID && mac_d_TREADY;
            m_can_push = (q.size() < CMD_DEPTH);
            d_new      = '{mul: cmd_simple_mul, sh: cmd_shift, len: cmd_len, nout: cmd_nout};
            e_done = 0;
            e_err  = 0;
            if (clear_i) begin
                q.delete();
                j_load = 0; j_run = 0; j_end = 0;
            end else begin
                if (j_end) begin
                    j_end = 0;
                end else if (j_load) begin
                    j_load = 0; j_run = 1; j_runcyc = 0;
                end else if (j_run) begin
                    j_runcyc++;
                    if (m_hs) j_left--;
                    if (j_left == 0) begin
                        j_run = 0; j_end = 1; e_done = 1;
                        e_jobcnt = e_jobcnt + 16'd1;
`ifdef MAC_SCHED_PERF_EN
                        e_perf = 32'(j_runcyc);
`endif
                    end
                end else if (q.size() > 0) begin
                    d_pop = q.pop_front();
                    e_mul = d_pop.mul; e_sh = d_pop.sh; e_len = d_pop.len;
                    if (d_pop.nout == 0) begin
                        j_end = 1; e_done = 1; e_err = 1; e_perf = 32'd0;
                    end else begin
                        j_load = 1; j_left = int'(d_pop.nout);
                    end
                end
                if (cmd_TVALID && m_can_push) q.push_back(d_new);
            end
            if (wrap_preload) e_jobcnt = 16'hFFFF;
            e_stream = j_run;
            e_busy   = j_load || j_run || j_end || (q.size() > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge ap_clk);
        if (chk_en) begin
            chk("cmd_TREADY", 32'(cmd_TREADY), 32'(q.size() < CMD_DEPTH));
            chk("mac_reg_simple_mul", 32'(mac_reg_simple_mul), 32'(e_mul));
            chk("mac_reg_shift", 32'(mac_reg_shift), 32'(e_sh));
            chk("mac_reg_len", 32'(mac_reg_len), 32'(e_len));
            chk("stream_en_o", 32'(stream_en_o), 32'(e_stream));
            chk("busy_o", 32'(busy_o), 32'(e_busy));
            chk("done_o", 32'(done_o), 32'(e_done));
            chk("err_o", 32'(err_o), 32'(e_err));
            chk("job_cnt_o", 32'(job_cnt_o), 32'(e_jobcnt));
            chk("perf_cycles_o", perf_cycles_o, e_perf);
        end
    end

    // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
    task automatic push_job(input logic mul, input logic [4:0] sh, input logic [LEN_W-1:0] len,
                            input logic [NOUT_W-1:0] nout);
        int guard = 0;
        cmd_simple_mul = mul; cmd_shift = sh; cmd_len = len; cmd_nout = nout;
        cmd_TVALID = 1'b1;
        while (!cmd_TREADY && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!cmd_TREADY) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: cmd_TREADY got 0, expected 1 within 200 cycles");
        end
        @(negedge ap_clk);
        cmd_TVALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0 && n < 300) begin
            @(negedge ap_clk);
            n++;
        end
        if (busy_o !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle: busy_o got %b, expected 0 within 300 cycles", busy_o);
        end
        @(negedge ap_clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (done_o !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done: done_o got %b, expected 1 within 100 cycles", done_o);
        end
    endtask

    bit prev_ready;
    logic [15:0] jc_base;

    initial begin
        // reset state
        repeat (3) @(negedge ap_clk);
        chk("rst_cmd_TREADY", 32'(cmd_TREADY), 32'd1);
        chk("rst_stream", 32'(stream_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
        chk("rst_mac_reg", {20'd0, mac_reg_len}, 32'd0);
        chk("rst_job_cnt", 32'(job_cnt_o), 32'd0);
        chk("rst_perf", perf_cycles_o, 32'd0);
        ap_rst_n = 1'b1;
        chk_en   = 1'b1;
        @(negedge ap_clk);

        // single job, 4 consecutive handshakes
        push_job(1'b1, 5'd3, 12'd0, 16'd4);
        chk("single_busy_c1", 32'(busy_o), 32'd1);
        @(negedge ap_clk);
        chk("single_mac_reg_c2", {25'd0, mac_reg_simple_mul, mac_reg_shift, 1'b0}, {25'd0, 1'b1, 5'd3, 1'b0});
        chk("single_len_c2", 32'(mac_reg_len), 32'd0);
        chk("single_stream_c2", 32'(stream_en_o), 32'd0);
        @(negedge ap_clk);
        chk("single_stream_c3", 32'(stream_en_o), 32'd1);
        mac_d_TVALID = 1'b1; mac_d_TREADY = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("single_stream_c6", 32'(stream_en_o), 32'd1);
        @(negedge ap_clk);
        mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
        chk("single_done_c7", 32'(done_o), 32'd1);
        chk("single_stream_c7", 32'(stream_en_o), 32'd0);
        chk("single_job_cnt", 32'(job_cnt_o), 32'd1);
`ifdef MAC_SCHED_PERF_EN
        chk("single_perf", perf_cycles_o, 32'd4);
`else
        chk("single_perf", perf_cycles_o, 32'd0);
`endif
        @(negedge ap_clk);
        chk("single_done_once", 32'(done_o), 32'd0);
        wait_idle();

        // back-pressure: TREADY 1,0,0,1 with TVALID held high
        push_job(1'b0, 5'd7, 12'd9, 16'd4);
        @(negedge ap_clk); @(negedge ap_clk);
        for (int i = 0; i < 8; i++) begin
            mac_d_TVALID = 1'b1;
            mac_d_TREADY = ((i % 4) == 0) || ((i % 4) == 3);
            if (i == 7) chk("bp_done_early", 32'(done_o), 32'd0);
            @(negedge ap_clk);
        end
        mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
        chk("bp_done", 32'(done_o), 32'd1);
        chk("bp_job_cnt", 32'(job_cnt_o), 32'd2);
        chk("bp_mac_reg_shift", 32'(mac_reg_shift), 32'd7);
        wait_idle();

        // zero-length job
        push_job(1'b1, 5'd1, 12'd2, 16'd0);
        chk("zero_stream_c1", 32'(stream_en_o), 32'd0);
        @(negedge ap_clk);
        chk("zero_done_err_c2", {30'd0, done_o, err_o}, 32'd3);
        chk("zero_stream_c2", 32'(stream_en_o), 32'd0);
        chk("zero_job_cnt", 32'(job_cnt_o), 32'd2);
        @(negedge ap_clk);
        chk("zero_stream_c3", 32'(stream_en_o), 32'd0);
        wait_idle();

        // clear during RUN after 2 of 4 handshakes, one job queued
        push_job(1'b0, 5'd2, 12'd5, 16'd4);
        push_job(1'b1, 5'd9, 12'd6, 16'd2);
        @(negedge ap_clk);
        mac_d_TVALID = 1'b1; mac_d_TREADY = 1'b1;
        @(negedge ap_clk); @(negedge ap_clk);
        mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
        clear_i = 1'b1;
        @(negedge ap_clk);
        clear_i = 1'b0;
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_stream", 32'(stream_en_o), 32'd0);
        chk("clr_done", 32'(done_o), 32'd0);
        chk("clr_mac_reg_shift", 32'(mac_reg_shift), 32'd2);
        chk("clr_job_cnt", 32'(job_cnt_o), 32'd2);
        repeat (2) @(negedge ap_clk);
        chk("clr_fifo_empty", 32'(busy_o), 32'd0);

        // FIFO full while the first job runs
        push_job(1'b1, 5'd10, 12'd100, 16'd4);
        @(negedge ap_clk); @(negedge ap_clk);
        push_job(1'b0, 5'd11, 12'd101, 16'd2);
        push_job(1'b1, 5'd12, 12'd102, 16'd3);
        chk("full_ready", 32'(cmd_TREADY), 32'd0);
        jc_base = job_cnt_o;
        fork
            push_job(1'b0, 5'd13, 12'd103, 16'd1);
            begin
                mac_d_TVALID = 1'b1; mac_d_TREADY = 1'b1;
                repeat (60) @(negedge ap_clk);
                mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
            end
        join
        wait_idle();
        chk("full_job_cnt", 32'(job_cnt_o), 32'd6);
        chk("full_last_shift", 32'(mac_reg_shift), 32'd13);

        // job counter wrap
        force dut.job_cnt_r = 16'hFFFF;
        #1 wrap_preload = 1'b1;
        @(posedge ap_clk);
        #1 wrap_preload = 1'b0;
        @(negedge ap_clk);
        #1 release dut.job_cnt_r;
        @(negedge ap_clk);
        mac_d_TVALID = 1'b1; mac_d_TREADY = 1'b1;
        push_job(1'b1, 5'd4, 12'd7, 16'd4);
        wait_done();
        chk("wrap_job_cnt", 32'(job_cnt_o), 32'd0);
`ifdef MAC_SCHED_PERF_EN
        chk("wrap_perf", perf_cycles_o, 32'd4);
`else
        chk("wrap_perf", perf_cycles_o, 32'd0);
`endif
        mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
        wait_idle();

        // randomized traffic, checked by the model every cycle
        prev_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!(cmd_TVALID && !prev_ready)) begin
                cmd_TVALID     = ($urandom_range(0, 2) != 0);
                cmd_simple_mul = 1'($urandom_range(0, 1));
                cmd_shift      = 5'($urandom);
                cmd_len        = LEN_W'($urandom);
                cmd_nout       = NOUT_W'($urandom_range(0, 5));
            end
            mac_d_TVALID = ($urandom_range(0, 3) != 0);
            mac_d_TREADY = ($urandom_range(0, 3) != 0);
            clear_i      = ($urandom_range(0, 63) == 0);
            prev_ready   = cmd_TREADY;
            @(negedge ap_clk);
        end
        cmd_TVALID = 1'b0; clear_i = 1'b0;
        mac_d_TVALID = 1'b1; mac_d_TREADY = 1'b1;
        wait_idle();
        mac_d_TVALID = 1'b0; mac_d_TREADY = 1'b0;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_job_sched.md
# mac_job_sched

Job scheduler and configuration sequencer for the streaming MAC datapath. It accepts job descriptors (mode, shift, vector length, expected output count) through a small command FIFO. It drives the MAC configuration registers stable for the duration of each job and gates the upstream a/b/c stream sources. It counts handshakes on the MAC output stream d to detect job completion. It sits between the HWPE register file/controller and the MAC engine.

## Interface
- CMD_DEPTH, 2, command FIFO depth (power of two, ≥2)
- MAC_CNT_LEN, 4096, maximum scalar-product length; LEN_W = $clog2(MAC_CNT_LEN)
- NOUT_W, 16, width of the per-job output count
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear (flush and abort)
- cmd_TVALID  in  1  descriptor valid
- cmd_TREADY  out  1  descriptor accepted; equals !fifo_full
- cmd_simple_mul  in  1  job mode (1 = element-wise multiply)
- cmd_shift  in  5  output shift
- cmd_len  in  LEN_W  scalar-product length field for the MAC
- cmd_nout  in  NOUT_W  number of d handshakes that end the job
- mac_reg_simple_mul  out  1  to MAC
- mac_reg_shift  out  5  to MAC
- mac_reg_len  out  LEN_W  to MAC
- mac_d_TVALID  in  1  monitored MAC output valid
- mac_d_TREADY  in  1  monitored MAC output ready
- stream_en_o  out  1  enables the upstream a/b/c streamers
- busy_o  out  1  state ≠ IDLE or FIFO non-empty
- done_o  out  1  one-cycle pulse per finished job
- err_o  out  1  one-cycle pulse, zero-length job (cmd_nout == 0)
- job_cnt_o  out  16  completed-job counter, wraps 0xFFFF→0
- perf_cycles_o  out  32  RUN-cycle count of the last job (see Configuration)

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE.** If the FIFO is non-empty, pop the head at the clock edge.
  - Latch simple_mul, shift, len and nout into the mac_reg_* outputs and internal registers.
  - Go to LOAD if nout ≠ 0, otherwise go to DONE with the error flag set.
- **LOAD.** Hold for one cycle so the configuration settles at the MAC. stream_en_o = 0. Clear the output counter. Go to RUN.
- **RUN.** stream_en_o = 1.
  - Each cycle with mac_d_TVALID & mac_d_TREADY increments out_cnt.
  - A handshake while out_cnt == nout−1 goes to DONE.
  - Handshakes seen outside RUN are ignored.
- **DONE.** stream_en_o = 0 for one cycle.
  - done_o = 1 every time DONE is entered, including error jobs.
  - err_o = 1 if and only if the job had nout == 0.
  - job_cnt_o increments for non-error jobs only.
  - Go to IDLE.
- mac_reg_* hold their last value outside LOAD/RUN and change only on a pop.
- FIFO behaviour:
  - Push on cmd_TVALID & cmd_TREADY.
  - When full, cmd_TREADY = 0. A descriptor offered while full is held by the source and not lost.
  - Push and pop in the same cycle is legal whenever not full; occupancy stays unchanged.
- clear_i takes priority over everything except reset:
  - Empty the FIFO and go to IDLE.
  - stream_en_o = 0, no done_o or err_o pulse.
  - mac_reg_* and job_cnt_o are retained.
  - A cmd handshake in the same cycle as clear_i is discarded.
- Reset mid-job: same effect as clear_i, plus every register goes to its reset value.

## Timing
- Reset values:
  - cmd_TREADY = 1.
  - mac_reg_simple_mul, mac_reg_shift and mac_reg_len = 0.
  - stream_en_o, busy_o, done_o and err_o = 0.
  - job_cnt_o and perf_cycles_o = 0.
  - State = IDLE.
- Descriptor accepted in cycle 0 with the FIFO empty and the FSM in IDLE:
  - cycle 1: busy_o = 1; the pop happens at the end of cycle 1.
  - cycle 2: LOAD, with new mac_reg_* visible.
  - cycle 3: RUN, stream_en_o = 1.
- Last d handshake in cycle k: DONE in cycle k+1 (done_o = 1, stream_en_o = 0); IDLE in cycle k+2; the next job's earliest LOAD is in cycle k+3.
- Zero-length job popped at the end of cycle 1: DONE (done_o = err_o = 1) in cycle 2.
- stream_en_o is registered; done_o, err_o and busy_o are registered; cmd_TREADY is combinational from FIFO occupancy only.

## Configuration
- MAC_SCHED_PERF_EN defined:
  - A 32-bit counter clears in LOAD and increments every RUN cycle, saturating at 0xFFFFFFFF.
  - The counter value is copied to perf_cycles_o on entry to DONE, including on error jobs, where it reads 0.
- MAC_SCHED_PERF_EN undefined: no counter logic; perf_cycles_o is tied to 0.

## Test plan
- Single job: push simple_mul=1, shift=3, len=0, nout=4; give 4 d handshakes with mac_d_TREADY=1.
  - Required: mac_reg_* = (1, 3, 0) from cycle 2, stream_en_o high from cycle 3 until the 4th handshake, done_o pulses once, job_cnt_o = 1.
- Back-pressure: same job with mac_d_TREADY toggling 1,0,0,1 while mac_d_TVALID = 1.
  - Required: only cycles with both signals high count, and done_o follows the 4th true handshake.
- FIFO full: push 3 jobs back-to-back with CMD_DEPTH = 2 while the first is in RUN.
  - Required: cmd_TREADY = 0 after the 2nd push; the 3rd is accepted after the next pop; all 3 done_o pulses arrive in order with the correct mac_reg_* for each.
- Zero-length job: push nout=0.
  - Required: LOAD/RUN are skipped, done_o and err_o pulse in cycle 2, job_cnt_o is unchanged, stream_en_o is never asserted.
- clear_i during RUN after 2 of 4 handshakes, with 1 job queued.
  - Required: next cycle IDLE, FIFO empty, busy_o = 0, no done_o.
- Counter wrap: preload job_cnt_o to 0xFFFF through 65535 jobs with nout=1 (or by forcing), then run 1 job.
  - Required: job_cnt_o = 0x0000.
  - With MAC_SCHED_PERF_EN: perf_cycles_o equals the RUN cycle count, e.g. 4 for 4 consecutive handshakes.
